// File: rtl/wb_write_arbiter.sv
// Register-file write-back arbiter: the pipeline write has priority, and auxiliary writes
// wait in a small FIFO. It also provides pending-write hazard checks and a starvation stall request.
module wb_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [ADDR_W-1:0]        pipe_waddr,
  input  logic [DATA_W-1:0]        pipe_wdata,
  input  logic                     aux_valid,
  output logic                     aux_ready,
  input  logic [ADDR_W-1:0]        aux_waddr,
  input  logic [DATA_W-1:0]        aux_wdata,
  output logic                     we,
  output logic [ADDR_W-1:0]        waddr,
  output logic [DATA_W-1:0]        wdata,
  input  logic [ADDR_W-1:0]        chk_addr1,
  input  logic [ADDR_W-1:0]        chk_addr2,
  output logic                     chk_hit1,
  output logic                     chk_hit2,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(STARVE_LIM + 1);

  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [AW-1:0]     r_age;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_pipe_take;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic [PW-1:0]     w_off;
  logic              w_hit1;
  logic              w_hit2;

  // Handshake: an aux write transfers on any edge where aux_valid && aux_ready.
  // aux_ready depends only on occupancy (never on a same-cycle pop) and is low during reset.
  assign aux_ready   = (r_count < CW'(DEPTH)) && !rst;
  assign w_pipe_take = pipe_we && (pipe_waddr != '0);
  assign w_empty     = (r_count == '0);
  assign w_pop       = !w_pipe_take && !w_empty;
  assign w_push      = aux_valid && aux_ready && (aux_waddr != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= aux_waddr;
      r_mem_data[r_wr_ptr] <= aux_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_age    <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      if (w_pipe_take) begin
        r_we    <= 1'b1;
        r_waddr <= pipe_waddr;
        r_wdata <= pipe_wdata;
      end else if (w_pop) begin
        r_we    <= 1'b1;
        r_waddr <= r_mem_addr[r_rd_ptr];
        r_wdata <= r_mem_data[r_rd_ptr];
      end else begin
        r_we    <= 1'b0;
      end

      // Age counts how long the current head has waited behind pipeline writes.
      if (w_empty || w_pop) r_age <= '0;
      else if (r_age != AW'(STARVE_LIM)) r_age <= r_age + 1'b1;
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    w_off  = '0;
    w_hit1 = (chk_addr1 != '0) && r_we && (r_waddr == chk_addr1);
    w_hit2 = (chk_addr2 != '0) && r_we && (r_waddr == chk_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_rd_ptr;
      if ({1'b0, w_off} < r_count) begin
        if ((chk_addr1 != '0) && (r_mem_addr[i] == chk_addr1)) w_hit1 = 1'b1;
        if ((chk_addr2 != '0) && (r_mem_addr[i] == chk_addr2)) w_hit2 = 1'b1;
      end
    end
  end

  assign we         = r_we;
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;
  assign chk_hit1   = w_hit1;
  assign chk_hit2   = w_hit2;
  assign stall_req  = (r_age == AW'(STARVE_LIM));
  assign fifo_count = r_count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: a reference model feeds an expected-write queue checked every cycle,
// and scenario tasks add directed checks.
module tb_wb_write_arbiter;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int DEPTH      = 4;
  localparam int STARVE_LIM = 8;
  localparam int EW         = ADDR_W + DATA_W;

  logic              clk;
  logic              rst;
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;
  logic              aux_valid;
  logic              aux_ready;
  logic [ADDR_W-1:0] aux_waddr;
  logic [DATA_W-1:0] aux_wdata;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic              chk_hit1;
  logic              chk_hit2;
  logic              stall_req;
  logic [$clog2(DEPTH):0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  wb_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_waddr(aux_waddr), .aux_wdata(aux_wdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
    .stall_req(stall_req), .fifo_count(fifo_count)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model and scoreboard
  logic [EW-1:0]     exp_q[$];
  logic [EW-1:0]     m_fifo[$];
  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_waddr = '0;
  int                m_age = 0;
  int                m_sz;
  logic              m_take;
  logic              m_pop;
  logic [EW-1:0]     m_ent;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_fifo.delete();
      exp_q.delete();
      m_we  = 1'b0;
      m_age = 0;
    end else begin
      m_sz   = m_fifo.size();
      m_take = pipe_we && (pipe_waddr != '0);
      m_pop  = !m_take && (m_sz > 0);
      if (m_take) begin
        exp_q.push_back({pipe_waddr, pipe_wdata});
        m_waddr = pipe_waddr;
      end else if (m_pop) begin
        m_ent   = m_fifo.pop_front();
        m_waddr = m_ent[EW-1:DATA_W];
        exp_q.push_back(m_ent);
      end
      m_we = m_take || m_pop;
      if (aux_valid && (m_sz < DEPTH) && (aux_waddr != '0))
        m_fifo.push_back({aux_waddr, aux_wdata});
      if ((m_sz == 0) || m_pop) m_age = 0;
      else if (m_age < STARVE_LIM) m_age = m_age + 1;
    end
  end

  function automatic logic exp_hit(input logic [ADDR_W-1:0] a);
    logic [EW-1:0] e;
    if (a == '0) return 1'b0;
    if (m_we && (m_waddr == a)) return 1'b1;
    foreach (m_fifo[i]) begin
      e = m_fifo[i];
      if (e[EW-1:DATA_W] == a) return 1'b1;
    end
    return 1'b0;
  endfunction

  logic [EW-1:0] sb_exp;
  logic          sb_bit;
  initial forever begin
    @(negedge clk);
    #1;
    n_checks++;
    if (we !== m_we) begin
      n_fail++;
      $display("FAIL sb_we: got %0b expected %0b at %0t", we, m_we, $time);
    end
    if (m_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: got write %0d:%h, expected queue empty", waddr, wdata);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({waddr, wdata} !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_write: got %0d:%h expected %0d:%h at %0t",
                   waddr, wdata, sb_exp[EW-1:DATA_W], sb_exp[DATA_W-1:0], $time);
        end
      end
    end
    n_checks++;
    if (fifo_count !== ($clog2(DEPTH)+1)'(m_fifo.size())) begin
      n_fail++;
      $display("FAIL sb_count: got %0d expected %0d at %0t", fifo_count, m_fifo.size(), $time);
    end
    n_checks++;
    sb_bit = !rst && (m_fifo.size() < DEPTH);
    if (aux_ready !== sb_bit) begin
      n_fail++;
      $display("FAIL sb_ready: got %0b expected %0b at %0t", aux_ready, sb_bit, $time);
    end
    n_checks++;
    sb_bit = (m_age == STARVE_LIM);
    if (stall_req !== sb_bit) begin
      n_fail++;
      $display("FAIL sb_stall: got %0b expected %0b at %0t", stall_req, sb_bit, $time);
    end
    n_checks++;
    if ((chk_hit1 !== exp_hit(chk_addr1)) || (chk_hit2 !== exp_hit(chk_addr2))) begin
      n_fail++;
      $display("FAIL sb_hit: got %0b%0b expected %0b%0b for addrs %0d,%0d at %0t",
               chk_hit1, chk_hit2, exp_hit(chk_addr1), exp_hit(chk_addr2),
               chk_addr1, chk_addr2, $time);
    end
  end

  // Driver tasks
  task automatic idle_inputs();
    pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    aux_valid = 1'b0; aux_waddr = '0; aux_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    chk_addr1 = '0; chk_addr2 = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({we, waddr, wdata, fifo_count, stall_req, aux_ready, chk_hit1, chk_hit2} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: we=%0b waddr=%0d wdata=%h cnt=%0d stall=%0b rdy=%0b hits=%0b%0b, required all zero",
               we, waddr, wdata, fifo_count, stall_req, aux_ready, chk_hit1, chk_hit2);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (aux_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %0b required 1", aux_ready);
    end
  endtask

  task automatic test_pipe_write();
    @(negedge clk);
    pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h1234;
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if ({we, waddr, wdata} !== {1'b1, 5'd5, 32'h1234}) begin
      n_fail++;
      $display("FAIL pipe_write: got we=%0b %0d:%h required 1 5:1234", we, waddr, wdata);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (we !== 1'b0) begin
      n_fail++;
      $display("FAIL pipe_write_clear: got we=%0b required 0", we);
    end
  endtask

  task automatic test_aux_hazard();
    @(negedge clk);
    aux_valid = 1'b1; aux_waddr = 5'd7; aux_wdata = 32'hA5A5; chk_addr1 = 5'd7;
    #1;
    n_checks++;
    if (aux_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL aux_ready: got %0b required 1", aux_ready);
    end
    @(negedge clk);
    aux_valid = 1'b0;
    #1;
    n_checks++;
    if ({fifo_count, chk_hit1, we} !== {3'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL aux_queued: got cnt=%0d hit1=%0b we=%0b required 1 1 0", fifo_count, chk_hit1, we);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({we, waddr, wdata, fifo_count} !== {1'b1, 5'd7, 32'hA5A5, 3'd0}) begin
      n_fail++;
      $display("FAIL aux_out: got we=%0b %0d:%h cnt=%0d required 1 7:a5a5 0", we, waddr, wdata, fifo_count);
    end
    @(negedge clk);
    chk_addr1 = '0;
  endtask

  task automatic test_fill_drain();
    int idx = 0;
    logic acc;
    logic pend = 1'b0;
    logic [ADDR_W-1:0] got[$];
    @(negedge clk);
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h33;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      aux_valid = 1'b1; aux_waddr = 5'(8 + idx); aux_wdata = 32'h800 + 32'(idx);
      #1;
      acc = aux_ready;
      @(negedge clk);
      if (acc) idx++;
    end
    aux_waddr = 5'd12; aux_wdata = 32'h80C;
    #1;
    n_checks++;
    if ({fifo_count, aux_ready, stall_req} !== {3'd4, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL fill_full: got cnt=%0d rdy=%0b stall=%0b required 4 0 0", fifo_count, aux_ready, stall_req);
    end
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_early: got %0b required 0 after 7 waits", stall_req);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (stall_req !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_rise: got %0b required 1 after 8 waits", stall_req);
    end
    pipe_we = 1'b0;
    for (int c = 0; c < 12 && got.size() < 5; c++) begin
      @(negedge clk);
      if (pend) aux_valid = 1'b0;
      #1;
      if (we) got.push_back(waddr);
      if (c == 0) begin
        n_checks++;
        if (stall_req !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_fall: got %0b required 0 after head pop", stall_req);
        end
      end
      pend = aux_valid && aux_ready;
    end
    aux_valid = 1'b0;
    n_checks++;
    if (got.size() != 5) begin
      n_fail++;
      $display("FAIL drain_len: got %0d writes required 5", got.size());
    end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== 5'(8 + i)) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: got %0d required %0d", i, got[i], 8 + i);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_r0();
    @(negedge clk);
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h3;
    aux_valid = 1'b1; aux_waddr = 5'd20; aux_wdata = 32'h2020;
    @(negedge clk);
    aux_valid = 1'b0;
    #1;
    n_checks++;
    if (fifo_count !== 3'd1) begin
      n_fail++;
      $display("FAIL r0_setup: got cnt=%0d required 1", fifo_count);
    end
    pipe_waddr = 5'd0; pipe_wdata = 32'hBAD0;
    @(negedge clk);
    pipe_we = 1'b0;
    #1;
    n_checks++;
    if ({we, waddr, wdata, fifo_count} !== {1'b1, 5'd20, 32'h2020, 3'd0}) begin
      n_fail++;
      $display("FAIL r0_pipe: got we=%0b %0d:%h cnt=%0d required 1 20:2020 0", we, waddr, wdata, fifo_count);
    end
    aux_valid = 1'b1; aux_waddr = 5'd0; aux_wdata = 32'hDEAD;
    #1;
    n_checks++;
    if (aux_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL r0_aux_ready: got %0b required 1", aux_ready);
    end
    @(negedge clk);
    aux_valid = 1'b0;
    #1;
    n_checks++;
    if ({fifo_count, we} !== {3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL r0_aux: got cnt=%0d we=%0b required 0 0", fifo_count, we);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] got[$];
    @(negedge clk);
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h3;
    aux_valid = 1'b1; aux_waddr = 5'd16; aux_wdata = 32'h1600;
    @(negedge clk);
    aux_waddr = 5'd17; aux_wdata = 32'h1700;
    @(negedge clk);
    #1;
    n_checks++;
    if (fifo_count !== 3'd2) begin
      n_fail++;
      $display("FAIL wrap_setup: got cnt=%0d required 2", fifo_count);
    end
    pipe_we = 1'b0;
    aux_waddr = 5'd18; aux_wdata = 32'h1800;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (fifo_count !== 3'd2) begin
        n_fail++;
        $display("FAIL wrap_count[%0d]: got %0d required 2", k, fifo_count);
      end
      if (we) got.push_back(waddr);
      if (k < 5) begin
        aux_waddr = 5'(19 + k); aux_wdata = 32'(19 + k) << 8;
      end else begin
        aux_valid = 1'b0;
      end
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      if (we) got.push_back(waddr);
    end
    n_checks++;
    if (got.size() != 8) begin
      n_fail++;
      $display("FAIL wrap_len: got %0d writes required 8", got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== 5'(16 + i)) begin
        n_fail++;
        $display("FAIL wrap_order[%0d]: got %0d required %0d", i, got[i], 16 + i);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h3;
    aux_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      aux_waddr = 5'(24 + k); aux_wdata = 32'hC0 + 32'(k);
      @(negedge clk);
    end
    aux_valid = 1'b0;
    #1;
    n_checks++;
    if ({fifo_count, we} !== {3'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL arst_setup: got cnt=%0d we=%0b required 3 1", fifo_count, we);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({we, waddr, wdata, fifo_count, aux_ready} !== '0) begin
      n_fail++;
      $display("FAIL arst_immediate: got we=%0b %0d:%h cnt=%0d rdy=%0b required all zero",
               we, waddr, wdata, fifo_count, aux_ready);
    end
    @(negedge clk);
    pipe_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (we !== 1'b0) begin
        n_fail++;
        $display("FAIL arst_stale[%0d]: got we=%0b waddr=%0d required we=0", k, we, waddr);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      pipe_we    = ($urandom_range(0, 99) < 45);
      pipe_waddr = 5'($urandom_range(0, 31));
      pipe_wdata = $urandom;
      aux_valid  = ($urandom_range(0, 99) < 50);
      aux_waddr  = 5'($urandom_range(0, 31));
      aux_wdata  = $urandom;
      chk_addr1  = 5'($urandom_range(0, 31));
      chk_addr2  = 5'($urandom_range(0, 31));
    end
    @(negedge clk);
    idle_inputs();
    repeat (DEPTH + 4) @(negedge clk);
    #1;
    n_checks++;
    if ((fifo_count !== 3'd0) || (m_fifo.size() != 0)) begin
      n_fail++;
      $display("FAIL random_drain: got cnt=%0d model=%0d required 0", fifo_count, m_fifo.size());
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_pipe_write();
    test_aux_hazard();
    test_fill_drain();
    test_r0();
    test_back_to_back();
    test_async_reset();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
